ubutterfly_decode: RTL and testbench

// - Downstream stage of the unary butterfly. Converts its four output bitstreams
//   (real0, img0, real1, img1) back to binary.
// - Counts the ones in each stream over one frame of N = 2**BITWIDTH sampled cycles.
//   A programmable warm-up window runs first and discards the butterfly pipeline fill.
// - Results leave on a valid/ready handshake to the next FFT stage or a readout register.
// - Consumer interprets bipolar value = 2*cnt/N - 1.

---
 rtl/ubutterfly_pkg.sv | 16 +
 rtl/ubutterfly_decode_if.sv | 30 +++
 rtl/ubs_count.sv | 34 +++
 rtl/ubutterfly_decode.sv | 118 +++++++++++
 tb/tb_ubutterfly_decode.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ubutterfly_pkg.sv
// Shared types and helpers for the unary butterfly decode stage.
package ubutterfly_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWarm = 2'd1,
    StAcc  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Frame length in sampled cycles for a given stream resolution.
  function automatic int unsigned frame_len(input int unsigned bitwidth);
    return 32'd1 << bitwidth;
  endfunction

endpackage

// File: rtl/ubutterfly_decode_if.sv
// Control, bitstream and result bundle between the butterfly, the decoder and its consumer.
interface ubutterfly_decode_if #(
  parameter int unsigned BITWIDTH = 8
);

  logic              iClr;
  logic              iStart;
  logic              iReady;
  logic              iReal0;
  logic              iImg0;
  logic              iReal1;
  logic              iImg1;
  logic              oBusy;
  logic              oValid;
  logic [BITWIDTH:0] oCntR0;
  logic [BITWIDTH:0] oCntI0;
  logic [BITWIDTH:0] oCntR1;
  logic [BITWIDTH:0] oCntI1;

  modport master (
    output iClr, iStart, iReady, iReal0, iImg0, iReal1, iImg1,
    input  oBusy, oValid, oCntR0, oCntI0, oCntR1, oCntI1
  );

  modport slave (
    input  iClr, iStart, iReady, iReal0, iImg0, iReal1, iImg1,
    output oBusy, oValid, oCntR0, oCntI0, oCntR1, oCntI1
  );

endinterface

// File: rtl/ubs_count.sv
// Ones counter for one unary bitstream; clear has priority over counting.
module ubs_count #(
  parameter int unsigned Width = 9
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iClr,
  input  logic             iEn,
  input  logic             iBit,
  output logic [Width-1:0] oCnt
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (iClr) begin
      cnt_d = '0;
    end else if (iEn && iBit) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oCnt = cnt_q;

endmodule

// File: rtl/ubutterfly_decode.sv
// Unary-to-binary decoder: discards SKIP warm-up cycles, then counts ones on four streams
// over N = 2**BITWIDTH cycles and offers the counts on a valid/ready handshake.
module ubutterfly_decode
  import ubutterfly_pkg::*;
#(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned SKIP     = 2
) (
  input  logic          iClk,
  input  logic          iRstN,
  ubutterfly_decode_if.slave bus
);

  localparam int unsigned N       = frame_len(BITWIDTH);
  localparam int unsigned WarmEnd = (SKIP == 0) ? 0 : SKIP - 1;
  localparam logic [BITWIDTH-1:0] PhaseLast = BITWIDTH'(N - 1);
  localparam logic [BITWIDTH-1:0] WarmLast  = BITWIDTH'(WarmEnd);

  state_e              state_q;
  logic [BITWIDTH-1:0] phase_q;
  logic                busy_q;
  logic                valid_q;
  logic                cnt_clr;
  logic                cnt_en;

  // Phase counter doubles as the warm-up counter; it is always zero on entry to ACC.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= StIdle;
      phase_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.iClr) begin
      state_q <= StIdle;
      phase_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.iStart) begin
            phase_q <= '0;
            busy_q  <= 1'b1;
            state_q <= (SKIP == 0) ? StAcc : StWarm;
          end
        end
        StWarm: begin
          if (phase_q == WarmLast) begin
            phase_q <= '0;
            state_q <= StAcc;
          end else begin
            phase_q <= phase_q + BITWIDTH'(1);
          end
        end
        StAcc: begin
          if (phase_q == PhaseLast) begin
            phase_q <= '0;
            state_q <= StDone;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            phase_q <= phase_q + BITWIDTH'(1);
          end
        end
        StDone: begin
          if (bus.iReady) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cnt_clr = bus.iClr || ((state_q == StIdle) && bus.iStart);
  assign cnt_en  = (state_q == StAcc);

  ubs_count #(.Width(BITWIDTH + 1)) u_cnt_r0 (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (cnt_clr),
    .iEn   (cnt_en),
    .iBit  (bus.iReal0),
    .oCnt  (bus.oCntR0)
  );

  ubs_count #(.Width(BITWIDTH + 1)) u_cnt_i0 (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (cnt_clr),
    .iEn   (cnt_en),
    .iBit  (bus.iImg0),
    .oCnt  (bus.oCntI0)
  );

  ubs_count #(.Width(BITWIDTH + 1)) u_cnt_r1 (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (cnt_clr),
    .iEn   (cnt_en),
    .iBit  (bus.iReal1),
    .oCnt  (bus.oCntR1)
  );

  ubs_count #(.Width(BITWIDTH + 1)) u_cnt_i1 (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (cnt_clr),
    .iEn   (cnt_en),
    .iBit  (bus.iImg1),
    .oCnt  (bus.oCntI1)
  );

  assign bus.oBusy  = busy_q;
  assign bus.oValid = valid_q;

endmodule

// File: tb/tb_ubutterfly_decode.sv
// Scoreboard bench for ubutterfly_decode at BITWIDTH=4 (N=16), SKIP=2 plus a SKIP=0 instance.
module tb_ubutterfly_decode;

  localparam int unsigned Bw   = 4;
  localparam int unsigned N    = 16;
  localparam int unsigned Skip = 2;

  typedef struct packed {
    logic [Bw:0] r0;
    logic [Bw:0] i0;
    logic [Bw:0] r1;
    logic [Bw:0] i1;
  } cnt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ubutterfly_decode_if #(.BITWIDTH(Bw)) bus ();
  ubutterfly_decode_if #(.BITWIDTH(Bw)) bus0 ();

  ubutterfly_decode #(.BITWIDTH(Bw), .SKIP(Skip)) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus)
  );

  ubutterfly_decode #(.BITWIDTH(Bw), .SKIP(0)) dut0 (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus0)
  );

  int   n_vec  = 0;
  int   n_miss = 0;
  cnt_t sb[$];

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bits(input logic r0, input logic i0, input logic r1, input logic i1);
    bus.iReal0 = r0;
    bus.iImg0  = i0;
    bus.iReal1 = r1;
    bus.iImg1  = i1;
  endtask

  task automatic check_counts(input string tag, input cnt_t e);
    check_val({tag, "_r0"}, bus.oCntR0, e.r0);
    check_val({tag, "_i0"}, bus.oCntI0, e.i0);
    check_val({tag, "_r1"}, bus.oCntR1, e.r1);
    check_val({tag, "_i1"}, bus.oCntI1, e.i1);
  endtask

  // Start a frame, drive warm-up and N samples; bit s of each pattern is sample s.
  task automatic drive_frame(input logic [N-1:0] pr0, input logic [N-1:0] pi0,
                             input logic [N-1:0] pr1, input logic [N-1:0] pi1,
                             input logic warm_val, input int start_at);
    cnt_t e;
    e.r0 = (Bw + 1)'($countones(pr0));
    e.i0 = (Bw + 1)'($countones(pi0));
    e.r1 = (Bw + 1)'($countones(pr1));
    e.i1 = (Bw + 1)'($countones(pi1));
    sb.push_back(e);
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    check_val("busy_start", bus.oBusy, 1);
    for (int k = 0; k < Skip; k++) begin
      set_bits(warm_val, warm_val, warm_val, warm_val);
      tick();
    end
    for (int s = 0; s < N; s++) begin
      set_bits(pr0[s], pi0[s], pr1[s], pi1[s]);
      bus.iStart = (s == start_at);
      if (s == N - 1) check_val("valid_early", bus.oValid, 0);
      tick();
    end
    bus.iStart = 1'b0;
    set_bits(1'b0, 1'b0, 1'b0, 1'b0);
    // Counting the start edge as edge 1, this is edge Skip+N+1.
    check_val("valid_lat", bus.oValid, 1);
    check_val("busy_done", bus.oBusy, 0);
  endtask

  task automatic collect(input int hold, input logic start_with_ready);
    cnt_t e;
    int   w = 0;
    while (!bus.oValid && w < 50) begin
      tick();
      w++;
    end
    check_val("valid_seen", bus.oValid, 1);
    check_val("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check_counts("cnt", e);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_val("hold_valid", bus.oValid, 1);
      check_counts("hold", e);
    end
    bus.iReady = 1'b1;
    bus.iStart = start_with_ready;
    tick();
    bus.iReady = 1'b0;
    bus.iStart = 1'b0;
    check_val("accept_valid", bus.oValid, 0);
    check_val("accept_busy", bus.oBusy, 0);
    check_counts("after", e);
    tick();
    check_val("no_restart", bus.oBusy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cnt_t zero;
    cnt_t e0;
    logic saw;
    zero = '0;
    bus.iClr = 1'b0;  bus.iStart = 1'b0;  bus.iReady = 1'b0;
    bus0.iClr = 1'b0; bus0.iStart = 1'b0; bus0.iReady = 1'b0;
    set_bits(1'b0, 1'b0, 1'b0, 1'b0);
    bus0.iReal0 = 1'b0; bus0.iImg0 = 1'b0; bus0.iReal1 = 1'b0; bus0.iImg1 = 1'b0;

    // Reset state
    #12;
    check_val("rst_busy", bus.oBusy, 0);
    check_val("rst_valid", bus.oValid, 0);
    check_counts("rst", zero);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    check_val("idle_busy", bus.oBusy, 0);
    check_val("idle_valid", bus.oValid, 0);

    // Full-scale streams with backpressure: 16/0/8/4
    drive_frame(16'hFFFF, 16'h0000, 16'h5555, 16'h1111, 1'b0, -1);
    collect(10, 1'b0);

    // Warm-up bits are discarded
    drive_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, -1);
    collect(0, 1'b0);

    // iStart during ACC ignored; iStart with iReady in DONE does not restart
    drive_frame(16'hA5C3, 16'h0F0F, 16'hFFFF, 16'h8001, 1'b0, 5);
    collect(2, 1'b1);

    // iStart together with iClr in IDLE: clear wins
    bus.iStart = 1'b1;
    bus.iClr   = 1'b1;
    tick();
    bus.iStart = 1'b0;
    bus.iClr   = 1'b0;
    check_val("clrstart_busy", bus.oBusy, 0);
    check_counts("clrstart", zero);
    tick();
    check_val("clrstart_idle", bus.oBusy, 0);

    // Abort with iClr at ACC sample 7
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    for (int k = 0; k < Skip; k++) begin
      set_bits(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int s = 0; s < 7; s++) begin
      set_bits(1'b1, 1'b1, 1'b1, 1'b1);
      tick();
    end
    check_val("pre_abort_r0", bus.oCntR0, 7);
    bus.iClr = 1'b1;
    tick();
    bus.iClr = 1'b0;
    set_bits(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("abort_busy", bus.oBusy, 0);
    check_val("abort_valid", bus.oValid, 0);
    check_counts("abort", zero);
    saw = 1'b0;
    repeat (Skip + N + 2) begin
      tick();
      saw |= bus.oValid;
    end
    check_val("abort_no_valid", saw, 0);

    // Asynchronous reset pulse mid-WARM
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    check_val("warm_busy", bus.oBusy, 1);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_busy", bus.oBusy, 0);
    check_val("arst_valid", bus.oValid, 0);
    #2 rst_n = 1'b1;
    saw = 1'b0;
    repeat (Skip + N + 3) begin
      tick();
      saw |= bus.oValid;
    end
    check_val("arst_no_valid", saw, 0);
    check_val("arst_idle", bus.oBusy, 0);

    // SKIP=0: the first sampled bit is counted
    e0.r0 = 1; e0.i0 = 1; e0.r1 = 1; e0.i1 = 1;
    sb.push_back(e0);
    bus0.iStart = 1'b1;
    tick();
    bus0.iStart = 1'b0;
    bus0.iReal0 = 1'b1; bus0.iImg0 = 1'b1; bus0.iReal1 = 1'b1; bus0.iImg1 = 1'b1;
    for (int s = 0; s < N; s++) begin
      if (s == 1) begin
        bus0.iReal0 = 1'b0; bus0.iImg0 = 1'b0; bus0.iReal1 = 1'b0; bus0.iImg1 = 1'b0;
      end
      if (s == N - 1) check_val("s0_valid_early", bus0.oValid, 0);
      tick();
    end
    check_val("s0_valid_lat", bus0.oValid, 1);
    check_val("s0_sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e0 = sb.pop_front();
      check_val("s0_r0", bus0.oCntR0, e0.r0);
      check_val("s0_i0", bus0.oCntI0, e0.i0);
      check_val("s0_r1", bus0.oCntR1, e0.r1);
      check_val("s0_i1", bus0.oCntI1, e0.i1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
